// File: rtl/rom_read_arbiter_if.sv
// Bus bundle between requesters, response consumer, ROM and the read arbiter.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface rom_read_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
);
    // Request channel, one valid/ready pair per requester.
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_ready;

    // Shared synchronous ROM read port.
    logic                  rom_rd_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;

    // Tagged response channel.
    logic                  resp_valid;
    logic [ID_WIDTH-1:0]   resp_id;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_ready;

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rom_rd_en,
        output rom_addr,
        input  rom_data,
        output resp_valid,
        output resp_id,
        output resp_data,
        input  resp_ready
    );

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rom_rd_en,
        input  rom_addr,
        output rom_data,
        input  resp_valid,
        input  resp_id,
        input  resp_data,
        output resp_ready
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one single-cycle-latency ROM read port among NUM_REQ
// requesters. Returned words are tagged with the requester index and queued in a
// 2-entry shift FIFO whose head register drives the response channel directly.
module rom_read_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
    input logic               clk,
    input logic               rst_b,
    rom_read_arbiter_if.slave bus
);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    // Arbitration state.
    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [ID_WIDTH-1:0] hi_idx, lo_idx, grant_idx;
    logic                hi_found, lo_found, grant_any;

    // In-flight ROM read (issued last cycle, data on rom_data this cycle).
    logic                inflight_q;
    logic [ID_WIDTH-1:0] inflight_id_q;

    // Response FIFO: head_q is the output register, tail_q the second slot.
    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    entry_t     push_entry;
    logic [1:0] fifo_count_q, fifo_count_d;
    logic       push, pop;

    // Credit accounting: FIFO occupancy plus the read still in the ROM pipeline.
    logic [2:0] outstanding;
    logic       credit_ok;

    assign push        = inflight_q;
    assign pop         = bus.resp_valid & bus.resp_ready;
    assign outstanding = 3'(fifo_count_q) + 3'(inflight_q);
    // A same-cycle pop frees a slot, so it counts toward the credit.
    assign credit_ok   = outstanding < (3'd2 + 3'(pop));

    // Round-robin pick: first valid at or above ptr, else first valid below ptr.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i]) begin
                if (i >= 32'(ptr_q)) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = ID_WIDTH'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = ID_WIDTH'(i);
                end
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
        // Gating with rst_b keeps every request-side output low while reset is held.
        grant_any = (hi_found | lo_found) & credit_ok & rst_b;
    end

    // Grant, ROM port drive and next pointer value.
    always_comb begin
        bus.req_ready = '0;
        bus.rom_rd_en = 1'b0;
        bus.rom_addr  = '0;
        ptr_d         = ptr_q;
        if (grant_any) begin
            bus.req_ready = NUM_REQ'(1) << grant_idx;
            bus.rom_rd_en = 1'b1;
            bus.rom_addr  = bus.req_addr[32'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
            if (32'(grant_idx) == NUM_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + ID_WIDTH'(1);
            end
        end
    end

    // Priority pointer and in-flight tracking; reset discards any read in the ROM.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ptr_q         <= '0;
            inflight_q    <= 1'b0;
            inflight_id_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            inflight_q <= grant_any;
            if (grant_any) begin
                inflight_id_q <= grant_idx;
            end
        end
    end

    // FIFO next state: shift on pop, write the first free slot on push.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        fifo_count_d = fifo_count_q;
        push_entry   = '{id: inflight_id_q, data: bus.rom_data};
        case ({push, pop})
            2'b10: begin
                if (fifo_count_q == 2'd0) begin
                    head_d = push_entry;
                end else begin
                    tail_d = push_entry;
                end
                fifo_count_d = fifo_count_q + 2'd1;
            end
            2'b01: begin
                // With one entry left the head simply goes invalid and keeps its value.
                if (fifo_count_q == 2'd2) begin
                    head_d = tail_q;
                end
                fifo_count_d = fifo_count_q - 2'd1;
            end
            2'b11: begin
                if (fifo_count_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_entry;
                end else begin
                    head_d = push_entry;
                end
            end
            default: begin
            end
        endcase
    end

    // FIFO storage and occupancy.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            head_q       <= '0;
            tail_q       <= '0;
            fifo_count_q <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    // Response channel comes straight from registers.
    always_comb begin
        bus.resp_valid = (fifo_count_q != 2'd0);
        bus.resp_id    = head_q.id;
        bus.resp_data  = head_q.data;
    end

    // The credit rule keeps the FIFO from ever being pushed while full without a pop.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_b)
        !(push && !pop && fifo_count_q == 2'd2));

    a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_b)
        $onehot0(bus.req_ready));

    a_count_range : assert property (@(posedge clk) disable iff (!rst_b)
        fifo_count_q <= 2'd2);

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter: vector table for the basic sequences,
// hand-written multi-cycle corner cases, and a grant-order scoreboard monitor.
module tb_rom_read_arbiter;

    localparam int NR = 4;

    logic clk;
    logic rst_b;

    rom_read_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(2), .DATA_WIDTH(32), .ID_WIDTH(2)) bus ();

    rom_read_arbiter #(
        .NUM_REQ   (4),
        .ADDR_WIDTH(2),
        .DATA_WIDTH(32),
        .ID_WIDTH  (2)
    ) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bus  (bus)
    );

    // ROM model: registered output, one cycle after rd_en.
    logic [31:0] rom_mem [4];
    logic [31:0] rom_q;
    initial begin
        rom_mem[0] = 32'h0001_0203;
        rom_mem[1] = 32'h0405_0607;
        rom_mem[2] = 32'h0809_0A0B;
        rom_mem[3] = 32'h0C0D_0E0F;
        rom_q      = '0;
    end
    always @(posedge clk) begin
        if (bus.rom_rd_en) rom_q <= rom_mem[bus.rom_addr];
    end
    assign bus.rom_data = rom_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    // Scoreboard of granted reads, in grant order, stamped with the grant cycle.
    typedef struct {
        int          id;
        logic [31:0] data;
        int          stamp;
    } sb_t;
    sb_t sb[$];

    int          m_cyc = 0;
    int          m_ptr = 0;
    int          m_g;
    logic        m_pop;
    logic        m_exp_rv;
    logic [3:0]  m_exp_ready;
    logic [1:0]  m_exp_addr;
    sb_t         m_e;

    // Monitor: predicts grants from its own round-robin/credit model and checks responses.
    always @(negedge clk) begin
        m_cyc++;
        if (!rst_b) begin
            chk("rst_req_ready", 32'(bus.req_ready), 0);
            chk("rst_rom_rd_en", 32'(bus.rom_rd_en), 0);
            chk("rst_rom_addr", 32'(bus.rom_addr), 0);
            chk("rst_resp_valid", 32'(bus.resp_valid), 0);
            chk("rst_resp_id", 32'(bus.resp_id), 0);
            chk("rst_resp_data", bus.resp_data, 0);
            sb.delete();
            m_ptr = 0;
        end else begin
            m_pop       = bus.resp_valid & bus.resp_ready;
            m_g         = -1;
            m_exp_ready = '0;
            m_exp_addr  = '0;
            if (sb.size() - int'(m_pop) < 2) m_g = rr_pick(bus.req_valid, m_ptr);
            if (m_g >= 0) begin
                m_exp_ready = 4'(1) << m_g;
                m_exp_addr  = bus.req_addr[m_g*2 +: 2];
            end
            chk("sb_req_ready", 32'(bus.req_ready), 32'(m_exp_ready));
            chk("sb_rom_rd_en", 32'(bus.rom_rd_en), 32'(m_g >= 0));
            chk("sb_rom_addr", 32'(bus.rom_addr), 32'(m_exp_addr));
            m_exp_rv = (sb.size() > 0) && (m_cyc - sb[0].stamp >= 2);
            chk("sb_resp_valid", 32'(bus.resp_valid), 32'(m_exp_rv));
            if (bus.resp_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_resp", 32'(bus.resp_id), 32'hFFFF_FFFF);
                end else begin
                    chk("sb_resp_id", 32'(bus.resp_id), 32'(sb[0].id));
                    chk("sb_resp_data", bus.resp_data, sb[0].data);
                    if (m_pop) void'(sb.pop_front());
                end
            end
            if (m_g >= 0) begin
                m_e.id    = m_g;
                m_e.data  = rom_mem[m_exp_addr];
                m_e.stamp = m_cyc;
                sb.push_back(m_e);
                m_ptr = (m_g + 1) % NR;
            end
            chk("fifo_bound", 32'(dut.fifo_count_q <= 2'd2), 1);
        end
    end

    typedef struct {
        bit          rst_before;
        logic [3:0]  valid;
        logic [7:0]  addr;
        logic        rready;
        logic [3:0]  e_ready;
        logic        e_rd_en;
        logic [1:0]  e_addr;
        logic        e_rvalid;
        logic [1:0]  e_id;
        logic [31:0] e_data;
    } vec_t;
    vec_t vecs[11];

    task automatic do_reset();
        rst_b          = 1'b0;
        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            if (sb.size() == 0) break;
        end
        chk("drain_empty", 32'(sb.size()), 0);
    endtask

    int         grants;
    logic [3:0] cur_valid;
    logic [7:0] cur_addr;
    logic [3:0] granted;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b          = 1'b0;
        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b0;

        // Single read by req 2 (addr 1), then all four from reset with addrs 3,2,1,0.
        vecs[0]  = '{1, 4'b0100, 8'h10, 1, 4'b0100, 1, 2'd1, 0, 2'd0, 32'h0};
        vecs[1]  = '{0, 4'b0000, 8'h00, 1, 4'b0000, 0, 2'd0, 0, 2'd0, 32'h0};
        vecs[2]  = '{0, 4'b0000, 8'h00, 1, 4'b0000, 0, 2'd0, 1, 2'd2, 32'h0405_0607};
        vecs[3]  = '{0, 4'b0000, 8'h00, 1, 4'b0000, 0, 2'd0, 0, 2'd0, 32'h0};
        vecs[4]  = '{1, 4'b1111, 8'h1B, 1, 4'b0001, 1, 2'd3, 0, 2'd0, 32'h0};
        vecs[5]  = '{0, 4'b1110, 8'h1B, 1, 4'b0010, 1, 2'd2, 0, 2'd0, 32'h0};
        vecs[6]  = '{0, 4'b1100, 8'h1B, 1, 4'b0100, 1, 2'd1, 1, 2'd0, 32'h0C0D_0E0F};
        vecs[7]  = '{0, 4'b1000, 8'h1B, 1, 4'b1000, 1, 2'd0, 1, 2'd1, 32'h0809_0A0B};
        vecs[8]  = '{0, 4'b0000, 8'h1B, 1, 4'b0000, 0, 2'd0, 1, 2'd2, 32'h0405_0607};
        vecs[9]  = '{0, 4'b0000, 8'h1B, 1, 4'b0000, 0, 2'd0, 1, 2'd3, 32'h0001_0203};
        vecs[10] = '{0, 4'b0000, 8'h1B, 1, 4'b0000, 0, 2'd0, 0, 2'd0, 32'h0};

        #1;
        for (int r = 0; r < 11; r++) begin
            if (vecs[r].rst_before) do_reset();
            bus.req_valid  = vecs[r].valid;
            bus.req_addr   = vecs[r].addr;
            bus.resp_ready = vecs[r].rready;
            @(negedge clk);
            chk($sformatf("vec%0d_req_ready", r), 32'(bus.req_ready), 32'(vecs[r].e_ready));
            chk($sformatf("vec%0d_rom_rd_en", r), 32'(bus.rom_rd_en), 32'(vecs[r].e_rd_en));
            chk($sformatf("vec%0d_rom_addr", r), 32'(bus.rom_addr), 32'(vecs[r].e_addr));
            chk($sformatf("vec%0d_resp_valid", r), 32'(bus.resp_valid), 32'(vecs[r].e_rvalid));
            if (vecs[r].e_rvalid) begin
                chk($sformatf("vec%0d_resp_id", r), 32'(bus.resp_id), 32'(vecs[r].e_id));
                chk($sformatf("vec%0d_resp_data", r), bus.resp_data, vecs[r].e_data);
            end
            next_cycle();
        end

        // Backpressure: req 1 keeps asking for addr 0 with the consumer stalled.
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'b0010;
        bus.req_addr   = 8'h00;
        grants = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.req_ready[1]) grants++;
            next_cycle();
        end
        chk("bp_grants", 32'(grants), 2);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("bp_stall_ready", 32'(bus.req_ready), 0);
            chk("bp_resp_valid", 32'(bus.resp_valid), 1);
            chk("bp_resp_id", 32'(bus.resp_id), 1);
            chk("bp_resp_data", bus.resp_data, 32'h0001_0203);
            next_cycle();
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_valid", 32'(bus.resp_valid), 1);
        chk("bp_pop_grant", 32'(bus.req_ready), 32'b0010);
        next_cycle();
        bus.resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_restall", 32'(bus.req_ready), 0);
        next_cycle();
        drain();

        // Pointer wrap and skip: grant 3, then 0 and 2 together give 0 then 2.
        bus.req_valid = 4'b1000;
        bus.req_addr  = 8'b10_00_00_00;
        @(negedge clk);
        chk("wrap_grant3", 32'(bus.req_ready), 32'b1000);
        next_cycle();
        bus.req_valid = 4'b0101;
        bus.req_addr  = 8'b00_11_00_01;
        @(negedge clk);
        chk("wrap_grant0", 32'(bus.req_ready), 32'b0001);
        next_cycle();
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("skip_grant2", 32'(bus.req_ready), 32'b0100);
        chk("skip_addr", 32'(bus.rom_addr), 3);
        next_cycle();
        drain();

        // Reset mid-flight: two reads outstanding, reset, then lowest valid index wins.
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'b0010;
        bus.req_addr   = 8'b00_00_10_00;
        next_cycle();
        next_cycle();
        rst_b          = 1'b0;
        bus.req_valid  = 4'b1111;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 0);
        chk("mid_rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("mid_rst_resp_data", bus.resp_data, 0);
        next_cycle();
        next_cycle();
        rst_b         = 1'b1;
        bus.req_valid = 4'b1100;
        bus.req_addr  = 8'b01_10_00_00;
        @(negedge clk);
        chk("post_rst_grant", 32'(bus.req_ready), 32'b0100);
        chk("post_rst_addr", 32'(bus.rom_addr), 2);
        next_cycle();
        bus.req_valid = 4'b1000;
        next_cycle();
        drain();

        // Random traffic with the consumer always ready; requests held until transfer.
        cur_valid      = '0;
        cur_addr       = '0;
        granted        = '0;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!cur_valid[i] || granted[i]) begin
                    cur_valid[i]       = ($urandom_range(0, 9) < 6);
                    cur_addr[i*2 +: 2] = 2'($urandom_range(0, 3));
                end
            end
            bus.req_valid = cur_valid;
            bus.req_addr  = cur_addr;
            @(negedge clk);
            granted = bus.req_valid & bus.req_ready;
            chk("tput_no_idle", 32'(bus.rom_rd_en), 32'(|bus.req_valid));
            next_cycle();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
